// File: rtl/keypad_entry.sv
// Keypad entry stage for the min:sec countdown timer: debounces the one-hot
// digit keys, builds a 3-digit BCD entry and issues load/clear strobes.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  keypad,
  input  logic        startn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        mag_on,
  output logic [11:0] data,
  output logic        load,
  output logic        clear,
  output logic [3:0]  entry_min,
  output logic [3:0]  entry_tens,
  output logic [3:0]  entry_ones,
  output logic        key_err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE} state_t;

  localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [9:0]  prev, prev_d;
  logic [1:0]  count;
  logic        startn_q, clearn_q;
  logic        key_valid, hit, accept, reject, start_evt, load_go;
  logic [3:0]  digit;
  logic [11:0] entry;

  assign key_valid = $onehot(keypad);
  assign entry     = {entry_min, entry_tens, entry_ones};
  assign start_evt = startn_q & ~startn;
  assign load_go   = clearn & start_evt & door_closed & (entry != 12'h000);
  // A debounced key is dropped when clear, start or the magnetron claims the cycle.
  assign accept    = hit & clearn & ~start_evt & ~mag_on;
  assign reject    = (count == 2'd3) || (entry_ones > 4'd5);

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (keypad[i]) digit = 4'(i);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    prev_d  = prev;
    hit     = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_d = DEBOUNCE;
          cnt_d   = 4'd0;
          prev_d  = keypad;
        end
      end
      DEBOUNCE: begin
        if (keypad == 10'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (key_valid && keypad == prev) begin
          if (cnt == LAST) begin
            hit     = 1'b1;
            state_d = RELEASE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt + 4'd1;
          end
        end else begin
          cnt_d  = 4'd0;
          prev_d = keypad;
        end
      end
      RELEASE: begin
        if (keypad == 10'd0) begin
          if (cnt == LAST) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt + 4'd1;
          end
        end else begin
          cnt_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (!clearn) begin
      state_d = (keypad != 10'd0) ? RELEASE : IDLE;
      cnt_d   = 4'd0;
    end
    if (mag_on) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      prev       <= 10'd0;
      count      <= 2'd0;
      entry_min  <= 4'd0;
      entry_tens <= 4'd0;
      entry_ones <= 4'd0;
      data       <= 12'h000;
      load       <= 1'b0;
      clear      <= 1'b0;
      key_err    <= 1'b0;
      startn_q   <= 1'b1;
      clearn_q   <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      prev     <= prev_d;
      startn_q <= startn;
      clearn_q <= clearn;
      load     <= load_go;
      clear    <= clearn_q & ~clearn;
      key_err  <= accept & reject;
      if (load_go) data <= entry;
      if (!clearn || load_go) begin
        count      <= 2'd0;
        entry_min  <= 4'd0;
        entry_tens <= 4'd0;
        entry_ones <= 4'd0;
      end else if (accept && !reject) begin
        count      <= count + 2'd1;
        entry_min  <= entry_tens;
        entry_tens <= entry_ones;
        entry_ones <= digit;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: strobes are scored against a queue of
// expected events; entry digits are checked inline by each scenario task.
module tb_keypad_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        resetn, startn, clearn, door_closed, mag_on;
  logic [9:0]  keypad;
  logic [11:0] data;
  logic        load, clear, key_err;
  logic [3:0]  entry_min, entry_tens, entry_ones;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum logic [1:0] {EV_LOAD, EV_CLEAR, EV_KERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [11:0] val;
  } ev_t;
  ev_t exp_q[$];

  keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .resetn(resetn), .keypad(keypad), .startn(startn),
    .clearn(clearn), .door_closed(door_closed), .mag_on(mag_on),
    .data(data), .load(load), .clear(clear), .entry_min(entry_min),
    .entry_tens(entry_tens), .entry_ones(entry_ones), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe the DUT produces must match the next expected event.
  task automatic score(input ev_kind_t kind, input logic [11:0] val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s got val=%h want no event", kind.name(), val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        n_fail++;
        $display("FAIL scoreboard got %s val=%h want %s val=%h",
                 kind.name(), val, e.kind.name(), e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (load === 1'b1)    score(EV_LOAD, data);
      if (clear === 1'b1)   score(EV_CLEAR, 12'h000);
      if (key_err === 1'b1) score(EV_KERR, 12'h000);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int d, input int hold, input int gap);
    keypad = 10'(1 << d);
    cyc(hold);
    keypad = 10'd0;
    cyc(gap);
  endtask

  task automatic push(input ev_kind_t kind, input logic [11:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic do_clear();
    push(EV_CLEAR, 12'h000);
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    cyc(2);
  endtask

  task automatic drain(input string name);
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_pending got %0d events outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; keypad = 10'd0; startn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; mag_on = 1'b0;
    cyc(3);
    n_tests++;
    if ({data, load, clear, key_err, entry_min, entry_tens, entry_ones} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got data=%h load=%b clear=%b err=%b entry=%h want all 0",
               data, load, clear, key_err, {entry_min, entry_tens, entry_ones});
    end
    resetn = 1'b1;
    cyc(2);
  endtask

  task automatic test_entry();
    press(1, 6, 6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h001) begin
      n_fail++; $display("FAIL entry_first got %h want 001", {entry_min, entry_tens, entry_ones});
    end
    press(3, 6, 6);
    press(0, 6, 6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h130) begin
      n_fail++; $display("FAIL entry_130 got %h want 130", {entry_min, entry_tens, entry_ones});
    end
    drain("entry");
  endtask

  task automatic test_start();
    push(EV_LOAD, 12'h130);
    startn = 1'b0;
    cyc(1);
    n_tests++;
    if (load !== 1'b1 || data !== 12'h130) begin
      n_fail++; $display("FAIL start_load got load=%b data=%h want load=1 data=130", load, data);
    end
    cyc(1);
    n_tests++;
    if (load !== 1'b0 || {entry_min, entry_tens, entry_ones} !== 12'h000) begin
      n_fail++; $display("FAIL start_after got load=%b entry=%h want load=0 entry=000",
                         load, {entry_min, entry_tens, entry_ones});
    end
    startn = 1'b1;
    cyc(3);
    n_tests++;
    if (data !== 12'h130) begin
      n_fail++; $display("FAIL data_hold got %h want 130", data);
    end
    // Door open: a start request must not load.
    press(2, 6, 6);
    door_closed = 1'b0;
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    door_closed = 1'b1;
    cyc(2);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h002 || data !== 12'h130) begin
      n_fail++; $display("FAIL door_open got entry=%h data=%h want entry=002 data=130",
                         {entry_min, entry_tens, entry_ones}, data);
    end
    do_clear();
    drain("start");
  endtask

  task automatic test_bounce();
    press(5, D - 1, 6);
    n_tests++;
    if (entry_ones !== 4'd0) begin
      n_fail++; $display("FAIL bounce got ones=%0d want 0", entry_ones);
    end
    keypad = 10'(1 << 5);
    cyc(D);
    n_tests++;
    if (entry_ones !== 4'd0) begin
      n_fail++; $display("FAIL latency_early got ones=%0d want 0", entry_ones);
    end
    cyc(1);
    n_tests++;
    if (entry_ones !== 4'd5) begin
      n_fail++; $display("FAIL latency_edge got ones=%0d want 5", entry_ones);
    end
    cyc(20);
    keypad = 10'd0;
    cyc(6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h005) begin
      n_fail++; $display("FAIL no_repeat got %h want 005", {entry_min, entry_tens, entry_ones});
    end
    do_clear();
    drain("bounce");
  endtask

  task automatic test_reject();
    press(7, 6, 6);
    push(EV_KERR, 12'h000);
    press(8, 6, 6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h007) begin
      n_fail++; $display("FAIL reject_tens got %h want 007", {entry_min, entry_tens, entry_ones});
    end
    do_clear();
    press(1, 6, 6);
    press(2, 6, 6);
    press(3, 6, 6);
    push(EV_KERR, 12'h000);
    press(4, 6, 6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h123) begin
      n_fail++; $display("FAIL reject_full got %h want 123", {entry_min, entry_tens, entry_ones});
    end
    do_clear();
    drain("reject");
  endtask

  task automatic test_lockout();
    keypad = 10'b0000000011;
    cyc(10);
    keypad = 10'd0;
    cyc(6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h000) begin
      n_fail++; $display("FAIL multi_key got %h want 000", {entry_min, entry_tens, entry_ones});
    end
    mag_on = 1'b1;
    press(4, 10, 2);
    mag_on = 1'b0;
    cyc(6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h000) begin
      n_fail++; $display("FAIL mag_on got %h want 000", {entry_min, entry_tens, entry_ones});
    end
    drain("lockout");
  endtask

  task automatic test_simultaneous();
    press(4, 6, 6);
    press(5, 6, 6);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h045) begin
      n_fail++; $display("FAIL setup_045 got %h want 045", {entry_min, entry_tens, entry_ones});
    end
    push(EV_CLEAR, 12'h000);
    clearn = 1'b0;
    startn = 1'b0;
    cyc(1);
    n_tests++;
    if (clear !== 1'b1 || load !== 1'b0 || {entry_min, entry_tens, entry_ones} !== 12'h000) begin
      n_fail++; $display("FAIL clear_vs_start got clear=%b load=%b entry=%h want 1 0 000",
                         clear, load, {entry_min, entry_tens, entry_ones});
    end
    cyc(1);
    n_tests++;
    if (clear !== 1'b0) begin
      n_fail++; $display("FAIL clear_pulse got clear=%b want 0", clear);
    end
    cyc(2);
    clearn = 1'b1;
    startn = 1'b1;
    cyc(2);
    drain("simultaneous");
  endtask

  task automatic test_reset_mid();
    press(2, 6, 6);
    keypad = 10'(1 << 9);
    cyc(2);
    resetn = 1'b0;
    keypad = 10'd0;
    cyc(1);
    n_tests++;
    if ({data, load, clear, key_err, entry_min, entry_tens, entry_ones} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid got data=%h load=%b clear=%b err=%b entry=%h want all 0",
               data, load, clear, key_err, {entry_min, entry_tens, entry_ones});
    end
    resetn = 1'b1;
    cyc(8);
    n_tests++;
    if ({entry_min, entry_tens, entry_ones} !== 12'h000) begin
      n_fail++; $display("FAIL partial_key got %h want 000", {entry_min, entry_tens, entry_ones});
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_entry();
    test_start();
    test_bounce();
    test_reject();
    test_lockout();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
